sequenciador_musica: RTL and testbench
======================================

// Module: sequenciador_musica
// PURPOSE
//  Playback controller for the note memory (memoria_notas).
//  Walks a 16-entry song from index 0 up to a programmable last index:
//    - drives the memory address and song select,
//    - absorbs the memory's 1-cycle registered read latency,
//    - holds each one-hot note for a fixed time, then a silent gap.
//  Feeds the tone generator / LED stage.
//  Lets the game FSM replay growing prefixes of a song each round.
// PARAMETERS
//  NOTE_TICKS  25_000_000  clock cycles each note is held (>=1)
//  GAP_TICKS   5_000_000   silent cycles between notes (0 = no gap state)
// PORTS
//  clock          in   1  system clock, all logic on posedge
//  reset          in   1  synchronous, active-high
//  iniciar        in   1  start pulse; sampled only in OCIOSO
//  parar          in   1  abort; any state -> OCIOSO next cycle
//  musica_in      in   3  song select, latched on accepted iniciar
//  ultima_nota    in   4  last index to play (0..15), latched on accepted iniciar
//  mem_dado       in   7  memory data_out (valid 1 cycle after address sampled)
//  mem_address    out  4  memory address (registered; = current note index)
//  mem_musica     out  3  memory select_musica (registered, latched copy)
//  nota           out  7  note being played; 0 when silent
//  nota_valida    out  1  high while nota is sounding (state TOCA)
//  ocupado        out  1  high in every state except OCIOSO
//  passo          out  1  1-cycle pulse on the last TOCA cycle of each note
//  pronto         out  1  1-cycle pulse (state FIM) after the final note
// BEHAVIOUR
//  Reset: state=OCIOSO; all outputs and counters 0.
//  States and transitions:
//    OCIOSO -> BUSCA on iniciar
//      latch musica_in/ultima_nota; mem_address<=0; tick counter<=0
//    BUSCA -> ESPERA (1 cycle; memory samples address at end of BUSCA)
//    ESPERA -> TOCA (1 cycle)
//      nota<=mem_dado on the exit edge; value stored verbatim, no one-hot check
//    TOCA: exactly NOTE_TICKS cycles; nota_valida=1; passo on the final cycle
//      mem_address==latched ultima -> FIM
//      else GAP_TICKS>0 -> PAUSA (nota<=0)
//      else -> BUSCA (mem_address+1, nota<=0)
//    PAUSA: exactly GAP_TICKS cycles, nota=0 -> BUSCA, mem_address+1
//    FIM -> OCIOSO (1 cycle); nota=0, pronto=1
//  Latency: iniciar edge to first nota_valida = 2 cycles.
//  Total run = (U+1)*(NOTE_TICKS+2) + U*GAP_TICKS cycles to FIM, U=ultima.
//  Address never wraps: max index 15 reached only when ultima=15.
//  Tick counter width $clog2(max(NOTE_TICKS,GAP_TICKS)+1); cleared on every state entry.
//  Boundary conditions:
//    iniciar outside OCIOSO: ignored (no restart, no relatch).
//    musica_in/ultima_nota changes mid-song: ignored.
//    parar: highest priority after reset, including same cycle as iniciar.
//      Next cycle: OCIOSO, nota=0, nota_valida=0, no pronto/passo.
//      mem_address/mem_musica keep their last value.
//    iniciar in the cycle after FIM (back in OCIOSO): accepted normally.
//    reset mid-song: identical to power-on reset on next edge.
// TESTING (bench NOTE_TICKS=4, GAP_TICKS=2; edge where iniciar sampled = E0)
//  1. musica_in=0, ultima=0, pulse iniciar
//     -> nota=7'b0100000, nota_valida high for E2..E5 cycles (4).
//     -> pronto high exactly 1 cycle after E6; ocupado low after E7.
//  2. musica_in=1, ultima=3
//     -> notes 0100000,0100000,0100000,0001000, each 4 cycles.
//     -> 2 silent cycles between notes; 4 passo pulses; pronto at E30.
//  3. musica_in=5, ultima=15
//     -> mem_address 0..15 in order, includes 7'b1000000 at index 11.
//     -> no wrap to 0; pronto once.
//  4. Start song 2, change musica_in and pulse iniciar during note 1
//     -> sequence and timing unchanged from song 2.
//  5. parar during second TOCA
//     -> next cycle OCIOSO, nota=0, no pronto.
//     -> new iniciar replays from index 0.
//  6. reset asserted in PAUSA
//     -> all outputs 0 next cycle.
//     -> GAP_TICKS=0 build: TOCA goes straight to BUSCA, run=(U+1)*6 cycles.

Source files
------------

// File: rtl/sequenciador_musica.sv
// ---------------------------------------------------------------------------
// sequenciador_musica
//
// Playback controller for the note memory (memoria_notas). It walks a song
// from index 0 up to a latched last index. For each note it drives the
// memory address, waits out the memory's one-cycle registered read, and
// holds the returned note for NOTE_TICKS cycles. It then inserts
// GAP_TICKS silent cycles before the next note. The game FSM uses it to
// replay growing prefixes of a song, one prefix per round.
//
// Parameters
//   NOTE_TICKS  cycles each note is held (>= 1)
//   GAP_TICKS   silent cycles between notes (0 removes the PAUSA state)
//
// Ports
//   clock        in   system clock, everything on posedge
//   reset        in   synchronous, active-high
//   iniciar      in   start pulse, only honoured while idle (OCIOSO)
//   parar        in   abort, returns to OCIOSO on the next edge
//   musica_in    in   [2:0] song select, latched when a start is accepted
//   ultima_nota  in   [3:0] last index to play, latched with musica_in
//   mem_dado     in   [6:0] memory data, valid one cycle after the address
//   mem_address  out  [3:0] registered memory address (current note index)
//   mem_musica   out  [2:0] registered copy of the latched song select
//   nota         out  [6:0] note being played, 0 while silent
//   nota_valida  out  high while nota is sounding (TOCA)
//   ocupado      out  high in every state except OCIOSO
//   passo        out  one-cycle pulse on the last TOCA cycle of each note
//   pronto       out  one-cycle pulse (FIM) after the final note
//   estado_dbg   out  [2:0] current FSM state encoding, for observation
//
// Control protocol: there is no backpressure. A start is accepted on any
// edge where iniciar is high, the FSM is in OCIOSO and parar is low.
// iniciar is ignored at every other time. Completion is reported by a
// single pronto cycle. parar outranks iniciar.
// ---------------------------------------------------------------------------
module sequenciador_musica #(
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [2:0] musica_in,
    input  logic [3:0] ultima_nota,
    input  logic [6:0] mem_dado,
    output logic [3:0] mem_address,
    output logic [2:0] mem_musica,
    output logic [6:0] nota,
    output logic       nota_valida,
    output logic       ocupado,
    output logic       passo,
    output logic       pronto,
    output logic [2:0] estado_dbg
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        BUSCA  = 3'd1,
        ESPERA = 3'd2,
        TOCA   = 3'd3,
        PAUSA  = 3'd4,
        FIM    = 3'd5
    } estado_t;

    localparam int unsigned MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int          TW        = $clog2(MAX_TICKS + 1);
    localparam bit          HAS_GAP   = (GAP_TICKS > 0);

    // Terminal counts. The counter starts at 0 on every state entry, so
    // the last cycle of a state of length N is the one where the count is N-1.
    localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = HAS_GAP ? TW'(GAP_TICKS - 1) : '0;

    estado_t       estado_q, estado_d;
    logic [3:0]    addr_q, addr_d;
    logic [2:0]    musica_q, musica_d;
    logic [3:0]    ultima_q, ultima_d;
    logic [6:0]    nota_q, nota_d;
    logic [TW-1:0] tick_q, tick_d;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            addr_q   <= '0;
            musica_q <= '0;
            ultima_q <= '0;
            nota_q   <= '0;
            tick_q   <= '0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            musica_q <= musica_d;
            ultima_q <= ultima_d;
            nota_q   <= nota_d;
            tick_q   <= tick_d;
        end
    end

    // Next state, next datapath values and state-decoded outputs
    always_comb begin
        estado_d    = estado_q;
        addr_d      = addr_q;
        musica_d    = musica_q;
        ultima_d    = ultima_q;
        nota_d      = nota_q;
        // Default to clearing: any state change restarts the count at 0.
        tick_d      = '0;
        nota_valida = 1'b0;
        passo       = 1'b0;
        pronto      = 1'b0;
        ocupado     = (estado_q != OCIOSO);

        case (estado_q)
            OCIOSO: begin
                nota_d = '0;
                if (iniciar) begin
                    estado_d = BUSCA;
                    musica_d = musica_in;
                    ultima_d = ultima_nota;
                    addr_d   = '0;
                end
            end

            // The address is already stable. The memory samples it on the
            // edge that leaves BUSCA.
            BUSCA: begin
                estado_d = ESPERA;
            end

            // Memory output is valid now. Capture it verbatim on exit.
            ESPERA: begin
                estado_d = TOCA;
                nota_d   = mem_dado;
            end

            TOCA: begin
                nota_valida = 1'b1;
                if (tick_q == NOTE_LAST) begin
                    passo  = 1'b1;
                    nota_d = '0;
                    if (addr_q == ultima_q) begin
                        estado_d = FIM;
                    end else if (HAS_GAP) begin
                        estado_d = PAUSA;
                    end else begin
                        estado_d = BUSCA;
                        addr_d   = addr_q + 4'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            PAUSA: begin
                if (tick_q == GAP_LAST) begin
                    estado_d = BUSCA;
                    addr_d   = addr_q + 4'd1;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            FIM: begin
                pronto   = 1'b1;
                estado_d = OCIOSO;
                nota_d   = '0;
            end

            default: begin
                estado_d = OCIOSO;
                nota_d   = '0;
            end
        endcase

        // Abort outranks everything except reset. The memory-facing
        // registers keep their last value, and a start seen in the same
        // cycle must not relatch them.
        if (parar) begin
            estado_d = OCIOSO;
            nota_d   = '0;
            tick_d   = '0;
            addr_d   = addr_q;
            musica_d = musica_q;
            ultima_d = ultima_q;
        end
    end

    assign mem_address = addr_q;
    assign mem_musica  = musica_q;
    assign nota        = nota_q;
    assign estado_dbg  = estado_q;

endmodule

// File: tb/tb_sequenciador_musica.sv
module tb_sequenciador_musica;

    localparam int NOTE_TICKS = 4;
    localparam int GAP_TICKS  = 2;
    localparam int P          = NOTE_TICKS + 2 + GAP_TICKS;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    // ---------------- main DUT (with gap) ----------------
    logic       iniciar, parar;
    logic [2:0] musica_in;
    logic [3:0] ultima_nota;
    logic [6:0] mem_dado;
    logic [3:0] mem_address;
    logic [2:0] mem_musica;
    logic [6:0] nota;
    logic       nota_valida, ocupado, passo, pronto;
    logic [2:0] estado_dbg;

    sequenciador_musica #(.NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .parar(parar),
        .musica_in(musica_in), .ultima_nota(ultima_nota), .mem_dado(mem_dado),
        .mem_address(mem_address), .mem_musica(mem_musica), .nota(nota),
        .nota_valida(nota_valida), .ocupado(ocupado), .passo(passo),
        .pronto(pronto), .estado_dbg(estado_dbg)
    );

    // ---------------- second DUT, no gap ----------------
    logic       iniciar0, parar0;
    logic [2:0] musica0;
    logic [3:0] ultima0;
    logic [6:0] mem_dado0;
    logic [3:0] addr0;
    logic [2:0] mus0;
    logic [6:0] nota0;
    logic       valid0, ocup0, passo0, pronto0;
    logic [2:0] dbg0;

    sequenciador_musica #(.NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(0)) dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar0), .parar(parar0),
        .musica_in(musica0), .ultima_nota(ultima0), .mem_dado(mem_dado0),
        .mem_address(addr0), .mem_musica(mus0), .nota(nota0),
        .nota_valida(valid0), .ocupado(ocup0), .passo(passo0),
        .pronto(pronto0), .estado_dbg(dbg0)
    );

    // Song contents used by the memory model (fixture data).
    function automatic logic [6:0] rom(input logic [2:0] s, input logic [3:0] a);
        logic [6:0] one;
        one = 7'b0000001;
        if (s == 3'd0 && a == 4'd0) return 7'b0100000;
        if (s == 3'd1 && a <= 4'd2) return 7'b0100000;
        if (s == 3'd1 && a == 4'd3) return 7'b0001000;
        if (s == 3'd5 && a == 4'd11) return 7'b1000000;
        if (s == 3'd2 && a == 4'd1) return 7'b1010101;
        return one << ((int'(s) + int'(a)) % 6);
    endfunction

    // Registered-read memory models
    always @(posedge clock) begin
        mem_dado  <= rom(mem_musica, mem_address);
        mem_dado0 <= rom(mus0, addr0);
    end

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Plays one song on the main DUT, called at a negedge.
    // mode 0: plain run, 1: disturb inputs during note 1,
    // 2: parar at cycle k_ev, 3: reset at cycle k_ev.
    task automatic play(input logic [2:0] s, input logic [3:0] u, input int mode, input int k_ev);
        int fim_k, i, o;
        logic [6:0] cur;
        logic e_v, e_p, e_r, e_o;
        logic [3:0] e_a;
        bit done;
        fim_k = int'(u) * P + NOTE_TICKS + 2;
        cur   = '0;
        done  = 0;
        musica_in   = s;
        ultima_nota = u;
        iniciar     = 1'b1;
        for (int n = 0; n <= int'(u); n++) exp_q.push_back(rom(s, 4'(n)));
        for (int k = 0; k <= fim_k + 1 && !done; k++) begin
            @(negedge clock);
            iniciar = 1'b0;
            if (mode >= 2 && k == k_ev + 1) begin
                check($sformatf("abort_nota k=%0d", k), nota, 0);
                check($sformatf("abort_valid k=%0d", k), nota_valida, 0);
                check($sformatf("abort_ocupado k=%0d", k), ocupado, 0);
                check($sformatf("abort_passo k=%0d", k), passo, 0);
                check($sformatf("abort_pronto k=%0d", k), pronto, 0);
                if (mode == 2) begin
                    check($sformatf("abort_addr k=%0d", k), mem_address, 4'(k_ev / P));
                    check($sformatf("abort_musica k=%0d", k), mem_musica, s);
                end else begin
                    check($sformatf("reset_addr k=%0d", k), mem_address, 0);
                    check($sformatf("reset_musica k=%0d", k), mem_musica, 0);
                end
                parar = 1'b0;
                reset = 1'b0;
                exp_q.delete();
                done = 1;
            end else begin
                i = k / P;
                o = k % P;
                if (k < fim_k) begin
                    e_o = 1'b1;
                    e_v = (o >= 2 && o < 2 + NOTE_TICKS);
                    e_p = (o == 1 + NOTE_TICKS);
                    e_r = 1'b0;
                    e_a = 4'(i);
                    if (o == 2) begin
                        if (exp_q.size() == 0) check($sformatf("queue_empty k=%0d", k), 1, 0);
                        else cur = exp_q.pop_front();
                    end
                end else if (k == fim_k) begin
                    e_o = 1'b1; e_v = 1'b0; e_p = 1'b0; e_r = 1'b1; e_a = u;
                end else begin
                    e_o = 1'b0; e_v = 1'b0; e_p = 1'b0; e_r = 1'b0; e_a = u;
                end
                check($sformatf("nota s=%0d k=%0d", s, k), nota, e_v ? cur : 7'd0);
                check($sformatf("valid s=%0d k=%0d", s, k), nota_valida, e_v);
                check($sformatf("passo s=%0d k=%0d", s, k), passo, e_p);
                check($sformatf("pronto s=%0d k=%0d", s, k), pronto, e_r);
                check($sformatf("ocupado s=%0d k=%0d", s, k), ocupado, e_o);
                check($sformatf("addr s=%0d k=%0d", s, k), mem_address, e_a);
                check($sformatf("musica s=%0d k=%0d", s, k), mem_musica, s);
                if (mode == 1 && k == P + 2) begin
                    iniciar     = 1'b1;
                    musica_in   = ~s;
                    ultima_nota = ~u;
                end
                if (mode == 2 && k == k_ev) parar = 1'b1;
                if (mode == 3 && k == k_ev) reset = 1'b1;
            end
        end
        if (!done) check("queue_drain", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pronto_k, pronto_n, valid_n, passo_n;
        reset = 1'b1; iniciar = 1'b0; parar = 1'b0; musica_in = '0; ultima_nota = '0;
        iniciar0 = 1'b0; parar0 = 1'b0; musica0 = '0; ultima0 = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_nota", nota, 0);
        check("rst_valid", nota_valida, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_passo", passo, 0);
        check("rst_pronto", pronto, 0);
        check("rst_addr", mem_address, 0);
        check("rst_musica", mem_musica, 0);
        reset = 1'b0;
        @(negedge clock);

        play(3'd0, 4'd0, 0, 0);       // single note
        play(3'd1, 4'd3, 0, 0);       // started in the cycle after FIM
        play(3'd5, 4'd15, 0, 0);      // full song, no wrap
        play(3'd2, 4'd3, 1, 0);       // mid-song iniciar/input changes ignored
        play(3'd1, 4'd3, 2, P + 3);   // parar during second TOCA
        play(3'd1, 4'd3, 0, 0);       // replay from index 0

        // parar together with iniciar: start refused, nothing relatched
        musica_in = 3'd4; ultima_nota = 4'd2; iniciar = 1'b1; parar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0; parar = 1'b0;
        check("parar_vs_iniciar_ocupado", ocupado, 0);
        check("parar_vs_iniciar_musica", mem_musica, 1);
        check("parar_vs_iniciar_addr", mem_address, 3);

        play(3'd3, 4'd2, 3, 6);       // reset during first PAUSA

        // No-gap build: TOCA goes straight back to BUSCA
        musica0 = 3'd1; ultima0 = 4'd2; iniciar0 = 1'b1;
        pronto_k = -1; pronto_n = 0; valid_n = 0; passo_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            iniciar0 = 1'b0;
            if (valid0) valid_n++;
            if (passo0) passo_n++;
            if (pronto0) begin pronto_n++; pronto_k = k; end
        end
        check("nogap_pronto_cycle", pronto_k, 3 * (NOTE_TICKS + 2));
        check("nogap_pronto_count", pronto_n, 1);
        check("nogap_valid_cycles", valid_n, 3 * NOTE_TICKS);
        check("nogap_passo_count", passo_n, 3);
        check("nogap_idle_after", ocup0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
